gen_sec: RTL and testbench

GEN_SEC -- requirements
Module: gen_sec

---
 rtl/gen_sec.sv | 211 +++++++++++++++++++++
 tb/tb_gen_sec.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/gen_sec.sv
// gen_sec: serial frame generator.
// A session starts with a sync pattern. Payload words follow MSB first, with a 1 stuffed after
// every N-1 consecutive zeros. When no word is ready the line idles with 1s (FILL). A fin
// request closes the session with the reinit pattern and returns to IDLE.
//
// Ports:
//   clk          - clock, rising edge
//   rst          - synchronous active-high reset
//   start        - begin a session (IDLE only)
//   fin          - request end of session (SYNC/DATA/FILL only)
//   dato         - payload word
//   dato_valido  - dato is valid; accepted when listo is also high
//   listo        - one-word holding buffer can accept a word
//   s_out        - registered serial output, one bit per clock
//   sincronizado - high in DATA or FILL
//   ocupado      - high whenever not IDLE
module gen_sec #(
  parameter int unsigned    N            = 5,
  parameter logic [N-1:0]   SECUENCIA    = 5'b10100,
  parameter logic [N-1:0]   SEC_REINICIO = 5'b00000,
  parameter int unsigned    W            = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         fin,
  input  logic [W-1:0] dato,
  input  logic         dato_valido,
  output logic         listo,
  output logic         s_out,
  output logic         sincronizado,
  output logic         ocupado
);

  localparam int unsigned CntMax = (N > W) ? N : W;
  localparam int unsigned CW     = $clog2(CntMax + 1);
  localparam int unsigned ZW     = (N > 1) ? $clog2(N) : 1;

  localparam logic [CW-1:0] CntN = CW'(N);
  localparam logic [CW-1:0] CntW = CW'(W);
  localparam logic [ZW-1:0] ZMax = ZW'(N - 1);

  typedef enum logic [4:0] {
    StIdle   = 5'b00001,
    StSync   = 5'b00010,
    StData   = 5'b00100,
    StFill   = 5'b01000,
    StReinit = 5'b10000
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;      // bits shown so far in the current segment
  logic [N-1:0]   pat_q, pat_d;      // remaining sync/reinit pattern bits
  logic [W-1:0]   sr_q, sr_d;        // remaining payload bits
  logic [W-1:0]   hold_q, hold_d;    // one-word holding buffer
  logic           lleno_q, lleno_d;
  logic           fin_pend_q, fin_pend_d;
  logic [ZW-1:0]  zeros_q, zeros_d;  // zero run on s_out, saturating at N-1
  logic           s_out_q, s_out_d;

  logic           accept;
  logic           in_session;
  logic           boundary;
  logic           shift_data;
  logic           load_word;
  logic [W-1:0]   word;
  logic [CW-1:0]  cnt_base;

  assign listo        = !rst && !lleno_q && !fin_pend_q;
  assign accept       = listo && dato_valido;
  assign in_session   = (state_q == StSync) || (state_q == StData) || (state_q == StFill);
  assign s_out        = s_out_q;
  assign sincronizado = (state_q == StData) || (state_q == StFill);
  assign ocupado      = (state_q != StIdle);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pat_d      = pat_q;
    sr_d       = sr_q;
    hold_d     = hold_q;
    lleno_d    = lleno_q;
    fin_pend_d = fin_pend_q;
    zeros_d    = zeros_q;
    s_out_d    = 1'b0;
    boundary   = 1'b0;
    shift_data = 1'b0;
    load_word  = 1'b0;
    word       = '0;
    cnt_base   = '0;

    if (accept) begin
      hold_d  = dato;
      lleno_d = 1'b1;
    end
    if (fin && in_session) begin
      fin_pend_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StSync;
          s_out_d = SECUENCIA[N-1];
          pat_d   = {SECUENCIA[N-2:0], 1'b0};
          cnt_d   = CW'(1);
        end
      end
      StSync: begin
        if (cnt_q == CntN) begin
          boundary = 1'b1;
        end else begin
          s_out_d = pat_q[N-1];
          pat_d   = {pat_q[N-2:0], 1'b0};
          cnt_d   = cnt_q + 1'b1;
        end
      end
      StData: begin
        if (cnt_q == CntW) begin
          boundary = 1'b1;
        end else begin
          shift_data = 1'b1;
        end
      end
      StFill: begin
        boundary = 1'b1;
      end
      StReinit: begin
        if (cnt_q == CntN) begin
          state_d    = StIdle;
          fin_pend_d = 1'b0;
          cnt_d      = '0;
        end else begin
          s_out_d = pat_q[N-1];
          pat_d   = {pat_q[N-2:0], 1'b0};
          cnt_d   = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Decision uses pre-edge lleno/fin_pend, so a word accepted on this edge waits one FILL bit.
    if (boundary) begin
      if (lleno_q) begin
        state_d   = StData;
        lleno_d   = 1'b0;
        load_word = 1'b1;
      end else if (fin_pend_q) begin
        state_d = StReinit;
        s_out_d = SEC_REINICIO[N-1];
        pat_d   = {SEC_REINICIO[N-2:0], 1'b0};
        cnt_d   = CW'(1);
      end else begin
        state_d = StFill;
        s_out_d = 1'b1;
      end
    end

    // Stuffing happens before a data bit, so it can never trail the last bit of a word.
    if (load_word || shift_data) begin
      word     = load_word ? hold_q : sr_q;
      cnt_base = load_word ? '0 : cnt_q;
      if (zeros_q == ZMax) begin
        s_out_d = 1'b1;
        sr_d    = word;
        cnt_d   = cnt_base;
      end else begin
        s_out_d = word[W-1];
        sr_d    = {word[W-2:0], 1'b0};
        cnt_d   = cnt_base + 1'b1;
      end
    end

    if (state_d == StIdle) begin
      zeros_d = '0;
    end else if (state_d != StReinit) begin
      if (s_out_d) begin
        zeros_d = '0;
      end else if (zeros_q != ZMax) begin
        zeros_d = zeros_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      pat_q      <= '0;
      sr_q       <= '0;
      hold_q     <= '0;
      lleno_q    <= 1'b0;
      fin_pend_q <= 1'b0;
      zeros_q    <= '0;
      s_out_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pat_q      <= pat_d;
      sr_q       <= sr_d;
      hold_q     <= hold_d;
      lleno_q    <= lleno_d;
      fin_pend_q <= fin_pend_d;
      zeros_q    <= zeros_d;
      s_out_q    <= s_out_d;
    end
  end

endmodule

// File: tb/tb_gen_sec.sv
// Bench for gen_sec: randomized and directed stimulus against a queue-based reference model.
module tb_gen_sec;

  localparam int N = 5;
  localparam int W = 8;
  localparam logic [N-1:0] SYNC_PAT  = 5'b10100;
  localparam logic [N-1:0] REINIT_PAT = 5'b00000;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         fin = 1'b0;
  logic [W-1:0] dato = '0;
  logic         dato_valido = 1'b0;
  logic         listo;
  logic         s_out;
  logic         sincronizado;
  logic         ocupado;

  int errors = 0;
  int checks = 0;

  gen_sec dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .fin          (fin),
    .dato         (dato),
    .dato_valido  (dato_valido),
    .listo        (listo),
    .s_out        (s_out),
    .sincronizado (sincronizado),
    .ocupado      (ocupado)
  );

  always #5 clk = ~clk;

  // Reference model: the segment being sent is a queue of bits still to appear on the line.
  typedef enum int {MIdle, MSync, MData, MFill, MReinit} phase_t;
  phase_t       m_ph = MIdle;
  bit           seg[$];
  bit           m_lleno = 0;
  bit [W-1:0]   m_buf = '0;
  bit           m_finp = 0;
  int           m_zrun = 0;
  bit           m_sout = 0;
  bit           m_valid = 0;

  logic [3:0]   exp_q[$];
  int           cyc_no = 0;

  function automatic void load_bits(input logic [W-1:0] v, input int len);
    seg.delete();
    for (int i = len - 1; i >= 0; i--) seg.push_back(v[i]);
  endfunction

  function automatic void emit_data();
    if (m_zrun == N - 1) m_sout = 1;
    else m_sout = seg.pop_front();
  endfunction

  function automatic void model_edge(input logic r, input logic st, input logic f,
                                     input logic [W-1:0] d, input logic dv);
    bit acc, fseen, bnd;
    if (r) begin
      m_ph = MIdle; seg.delete(); m_lleno = 0; m_finp = 0; m_zrun = 0; m_sout = 0;
      return;
    end
    acc   = !m_lleno && !m_finp && dv;
    fseen = f && (m_ph inside {MSync, MData, MFill});
    bnd   = ((m_ph inside {MSync, MData}) && seg.size() == 0) || m_ph == MFill;
    m_sout = 0;
    case (m_ph)
      MIdle: if (st) begin
        m_ph = MSync; load_bits({3'b0, SYNC_PAT}, N); m_sout = seg.pop_front();
      end
      MSync: if (!bnd) m_sout = seg.pop_front();
      MData: if (!bnd) emit_data();
      MReinit: begin
        if (seg.size() == 0) begin
          m_ph = MIdle; m_finp = 0; m_zrun = 0;
        end else m_sout = seg.pop_front();
      end
      default: ;
    endcase
    if (bnd) begin
      if (m_lleno) begin
        m_ph = MData; load_bits(m_buf, W); m_lleno = 0; emit_data();
      end else if (m_finp) begin
        m_ph = MReinit; load_bits({3'b0, REINIT_PAT}, N); m_sout = seg.pop_front();
      end else begin
        m_ph = MFill; m_sout = 1;
      end
    end
    if (m_ph inside {MSync, MData, MFill}) m_zrun = m_sout ? 0 : m_zrun + 1;
    if (acc) begin m_lleno = 1; m_buf = d; end
    if (fseen) m_finp = 1;
  endfunction

  // One clock: drive inputs, queue the expected outputs for this cycle, advance the model.
  task automatic cyc(input logic r, input logic st, input logic f,
                     input logic [W-1:0] d, input logic dv);
    rst = r; start = st; fin = f; dato = d; dato_valido = dv;
    if (m_valid)
      exp_q.push_back({m_sout, m_ph != MIdle, m_ph inside {MData, MFill},
                       !r && !m_lleno && !m_finp});
    @(posedge clk);
    model_edge(r, st, f, d, dv);
    if (r) m_valid = 1;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 8'h00, 0);
  endtask

  always @(negedge clk) begin
    logic [3:0] e, g;
    cyc_no++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = {s_out, ocupado, sincronizado, listo};
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL outputs cycle=%0d {s_out,ocupado,sincronizado,listo} got=%b exp=%b",
                 cyc_no, g, e);
      end
    end
  end

  logic [15:0] rec;
  logic [15:0] want_zero_word;

  initial begin
    // Reset, then idle line.
    cyc(1, 0, 0, 8'h00, 0);
    cyc(1, 0, 0, 8'h00, 0);
    idle(3);

    // Session without data, then close it.
    cyc(0, 1, 0, 8'h00, 0);
    idle(9);
    cyc(0, 0, 1, 8'h00, 0);
    idle(9);

    // Preloaded 8'hA5.
    cyc(0, 0, 0, 8'hA5, 1);
    cyc(0, 1, 0, 8'h00, 0);
    idle(16);
    cyc(0, 0, 1, 8'h00, 0);
    idle(9);

    // Preloaded 8'h00: sync, stuffed word, then FILL, against a fixed bit pattern.
    want_zero_word = 16'b1010_0001_0000_1001;
    cyc(0, 0, 0, 8'h00, 1);
    for (int i = 0; i < 16; i++) begin
      cyc(0, (i == 0), 0, 8'h00, 0);
      rec[15 - i] = s_out;
    end
    checks++;
    if (rec !== want_zero_word) begin
      errors++;
      $display("FAIL zero_word_stuffing got=%b exp=%b", rec, want_zero_word);
    end
    cyc(0, 0, 1, 8'h00, 0);
    idle(9);

    // Word accepted in FILL together with fin.
    cyc(0, 1, 0, 8'h00, 0);
    idle(7);
    cyc(0, 0, 1, 8'hFF, 1);
    idle(18);

    // start and fin together in IDLE, then reset mid-DATA with a word buffered.
    cyc(0, 1, 1, 8'h00, 0);
    idle(3);
    cyc(0, 0, 0, 8'h3C, 1);
    idle(3);
    cyc(0, 0, 0, 8'hC3, 1);
    idle(2);
    cyc(1, 0, 0, 8'h00, 0);
    idle(6);
    cyc(0, 0, 0, 8'h00, 0);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      logic [W-1:0] d;
      case ($urandom_range(3))
        0: d = 8'h00;
        1: d = 8'h80 >> $urandom_range(7);
        2: d = 8'hFF;
        default: d = 8'($urandom);
      endcase
      cyc(($urandom_range(199) == 0), ($urandom_range(7) == 0), ($urandom_range(24) == 0),
          d, ($urandom_range(1) == 1));
    end
    idle(2);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
